// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit between the execute stage and a simple request/grant memory bus.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  instruction handshake from the execute stage (ready only in IDLE)
//   in_is_load/store   memory op type; both low means ALU pass-through of in_alu
//   in_funct3          access size (bits [1:0]) and zero-extend flag (bit 2)
//   in_addr/in_wdata   effective byte address and LSB-aligned store data
//   in_alu/in_rd       non-memory result and destination register index
//   mem_req/we/addr    registered bus request, doubleword-aligned address
//   mem_wdata/wmask    lane-shifted store data and byte enables
//   mem_gnt            request accepted by the bus
//   mem_rvalid/rdata   bus response (read data for loads, completion for stores)
//   wb_en/addr/data    register-file write port (single-cycle pulse)
//   err                single-cycle pulse on misaligned access or response timeout
module ysyx_22040125_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [63:0] in_alu,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [63:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    // The counter holds the number of WAIT cycles already spent; the cycle in
    // which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              lat_is_load;
    logic [2:0]        lat_funct3;
    logic [2:0]        lat_off;
    logic [4:0]        lat_rd;

    logic              accept;
    logic              is_mem;
    logic              misaligned;
    logic              timeout;
    logic [3:0]        size_bytes;
    logic [7:0]        size_mask;
    logic [5:0]        lane_shift;

    // Select the addressed lane, truncate to the access size and extend.
    function automatic logic [63:0] extract_load(input logic [63:0] rdata,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  funct3);
        logic [63:0] lane;
        logic        sx;
        lane = rdata >> {off, 3'b000};
        sx   = ~funct3[2];
        case (funct3[1:0])
            2'd0:    extract_load = {{56{sx & lane[7]}},  lane[7:0]};
            2'd1:    extract_load = {{48{sx & lane[15]}}, lane[15:0]};
            2'd2:    extract_load = {{32{sx & lane[31]}}, lane[31:0]};
            default: extract_load = lane;
        endcase
    endfunction

    assign in_ready = (state == IDLE);

    // NOTE: every signal assigned in this block gets a value before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        accept     = (state == IDLE) && in_valid;
        is_mem     = in_is_load | in_is_store;
        size_bytes = 4'd1 << in_funct3[1:0];
        misaligned = ({1'b0, in_addr[2:0]} & (size_bytes - 4'd1)) != 4'd0;
        lane_shift = {in_addr[2:0], 3'b000};
        case (in_funct3[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        // A response in the final WAIT cycle takes priority over the timeout.
        timeout = (state == WAIT) && !mem_rvalid && (cnt == CNT_LAST);

        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem)          state_nx = WB;
                    else if (!misaligned) state_nx = REQ;
                end
            end
            REQ:  if (mem_gnt) state_nx = WAIT;
            WAIT: begin
                if (mem_rvalid)   state_nx = lat_is_load ? WB : IDLE;
                else if (timeout) state_nx = IDLE;
            end
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            // NOTE: the latched instruction fields are reset as well, so an
            // abandoned transaction leaves nothing stale behind.
            lat_is_load <= 1'b0;
            lat_funct3  <= 3'd0;
            lat_off     <= 3'd0;
            lat_rd      <= 5'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 64'd0;
            mem_wdata   <= 64'd0;
            mem_wmask   <= 8'd0;
            wb_en       <= 1'b0;
            wb_addr     <= 5'd0;
            wb_data     <= 64'd0;
            err         <= 1'b0;
        end else begin
            state   <= state_nx;
            mem_req <= (state_nx == REQ);
            err     <= (accept && is_mem && misaligned) || timeout;
            wb_en   <= 1'b0;
            cnt     <= (state == WAIT) ? cnt + 1'b1 : '0;

            if (accept) begin
                lat_is_load <= in_is_load;
                lat_funct3  <= in_funct3;
                lat_off     <= in_addr[2:0];
                lat_rd      <= in_rd;
                if (!is_mem) begin
                    wb_en   <= (in_rd != 5'd0);
                    wb_addr <= in_rd;
                    wb_data <= in_alu;
                end else if (!misaligned) begin
                    // Load takes priority if both op flags are set.
                    mem_addr  <= {in_addr[63:3], 3'b000};
                    mem_we    <= !in_is_load;
                    mem_wmask <= in_is_load ? 8'h00  : size_mask << in_addr[2:0];
                    mem_wdata <= in_is_load ? 64'd0 : in_wdata << lane_shift;
                end
            end

            if (state == REQ && mem_gnt) mem_we <= 1'b0;

            if (state == WAIT && mem_rvalid && lat_is_load) begin
                wb_en   <= (lat_rd != 5'd0);
                wb_addr <= lat_rd;
                wb_data <= extract_load(mem_rdata, lat_off, lat_funct3);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Testbench for ysyx_22040125_lsu: directed cases with literal expectations,
// a mid-transaction reset, then randomized transactions against a
// transaction-level model of the unit.
module tb_ysyx_22040125_lsu;

    localparam int T = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr, in_wdata, in_alu;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        wb_en, err;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    always #5 clk = ~clk;

    ysyx_22040125_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu(in_alu), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic        chk_en = 1'b0;
    logic        exp_rdy, exp_req, exp_we, exp_wb, exp_err;
    logic [63:0] exp_addr, exp_wdata, exp_wb_data;
    logic [7:0]  exp_wmask;
    logic [4:0]  exp_wb_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("mem_req",  64'(mem_req),  64'(exp_req));
            check("wb_en",    64'(wb_en),    64'(exp_wb));
            check("err",      64'(err),      64'(exp_err));
            if (exp_req) begin
                check("mem_we",   64'(mem_we), 64'(exp_we));
                check("mem_addr", mem_addr,    exp_addr);
                if (exp_we) begin
                    check("mem_wmask", 64'(mem_wmask), 64'(exp_wmask));
                    check("mem_wdata", mem_wdata,      exp_wdata);
                end
            end
            if (exp_wb) begin
                check("wb_addr", 64'(wb_addr), 64'(exp_wb_addr));
                check("wb_data", wb_data,      exp_wb_data);
            end
        end
    end

    // Load result: shift the addressed bytes down, keep nb bytes, extend.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                               input int nb, input logic unsigned_ld);
        logic [63:0] v, keep;
        v = rdata >> (8 * off);
        if (nb == 8) return v;
        keep = (64'd1 << (8 * nb)) - 64'd1;
        v = v & keep;
        if (!unsigned_ld && v[8 * nb - 1]) v = v | ~keep;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input logic rdy, input logic req, input logic wb, input logic er);
        exp_rdy = rdy;
        exp_req = req;
        exp_wb  = wb;
        exp_err = er;
    endtask

    // Random instruction fields; in_valid may only be raised while the unit is busy.
    task automatic drive_junk(input logic busy);
        in_valid    = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        in_is_load  = 1'($urandom_range(0, 1));
        in_is_store = 1'($urandom_range(0, 1));
        in_funct3   = 3'($urandom_range(0, 7));
        in_addr     = {$urandom, $urandom};
        in_wdata    = {$urandom, $urandom};
        in_alu      = {$urandom, $urandom};
        in_rd       = 5'($urandom_range(0, 31));
        mem_rvalid  = 1'($urandom_range(0, 1));
        mem_rdata   = {$urandom, $urandom};
    endtask

    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] alu, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input logic [63:0] rdata,
                           input logic lit_en, input logic [63:0] lit_val,
                           input logic [7:0] lit_mask);
        int          nb, off, k;
        logic        mis, done, ok;
        logic [7:0]  mask;
        logic [63:0] sdata, ld_val;
        nb     = 1 << f3[1:0];
        off    = int'(addr[2:0]);
        mis    = (ld || st) && (off % nb != 0);
        mask   = 8'(((1 << nb) - 1) << off);
        sdata  = wdata << (8 * off);
        ld_val = model_load(rdata, off, nb, f3[2]);
        if (lit_en) begin
            ld_val = lit_val;
            sdata  = lit_val;
            mask   = lit_mask;
        end

        drive_junk(1'b0);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_alu = alu; in_rd = rd;
        mem_gnt = 1'b0;
        expect_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tick();

        if (!ld && !st) begin
            drive_junk(1'b1);
            expect_cycle(1'b0, 1'b0, rd != 5'd0, 1'b0);
            exp_wb_addr = rd;
            exp_wb_data = lit_en ? lit_val : alu;
            tick();
        end else if (mis) begin
            drive_junk(1'b0);
            expect_cycle(1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end else begin
            exp_addr  = addr - 64'(off);
            exp_we    = st && !ld;
            exp_wmask = mask;
            exp_wdata = sdata;
            for (int g = 0; g <= gnt_dly; g++) begin
                drive_junk(1'b1);
                mem_gnt = (g == gnt_dly);
                expect_cycle(1'b0, 1'b1, 1'b0, 1'b0);
                tick();
            end
            mem_gnt = 1'b0;
            done = 1'b0; ok = 1'b0; k = 0;
            while (!done) begin
                drive_junk(1'b1);
                mem_rvalid = (k == rv_dly);
                if (mem_rvalid) mem_rdata = rdata;
                expect_cycle(1'b0, 1'b0, 1'b0, 1'b0);
                if (k == rv_dly) begin
                    ok = 1'b1; done = 1'b1;
                end else if (k == T - 1) begin
                    done = 1'b1;
                end
                tick();
                k++;
            end
            if (ok && ld) begin
                drive_junk(1'b1);
                expect_cycle(1'b0, 1'b0, rd != 5'd0, 1'b0);
                exp_wb_addr = rd;
                exp_wb_data = ld_val;
                tick();
            end else if (!ok) begin
                drive_junk(1'b0);
                expect_cycle(1'b1, 1'b0, 1'b0, 1'b1);
                tick();
            end
        end

        drive_junk(1'b0);
        expect_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic check_reset_values();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_mem_req",   64'(mem_req),   64'd0);
        check("rst_mem_we",    64'(mem_we),    64'd0);
        check("rst_wb_en",     64'(wb_en),     64'd0);
        check("rst_err",       64'(err),       64'd0);
        check("rst_mem_addr",  mem_addr,       64'd0);
        check("rst_mem_wdata", mem_wdata,      64'd0);
        check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        check("rst_wb_addr",   64'(wb_addr),   64'd0);
        check("rst_wb_data",   wb_data,        64'd0);
    endtask

    int          kind, nb, off, pick, rv, gd;
    logic        r_ld, r_st;
    logic [2:0]  r_f3;
    logic [63:0] r_addr;

    initial begin
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
        in_addr = 0; in_wdata = 0; in_alu = 0; in_rd = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        expect_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_wmask = 0; exp_wb_addr = 0; exp_wb_data = 0;

        #1 rst_n = 1'b0;
        #2 check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // ALU pass-through
        run_txn(0, 0, 3'd0, 64'h0, 64'h0, 64'h1234, 5'd5, 0, 0, 64'h0, 1, 64'h1234, 8'h00);
        // lb / lbu at 0x1003
        run_txn(1, 0, 3'd0, 64'h1003, 64'h0, 64'h0, 5'd10, 0, 1, 64'h00000000_80000000,
                1, 64'hFFFFFFFF_FFFFFF80, 8'h00);
        run_txn(1, 0, 3'd4, 64'h1003, 64'h0, 64'h0, 5'd11, 1, 0, 64'h00000000_80000000,
                1, 64'h80, 8'h00);
        // sh with grant delayed 3 cycles
        run_txn(0, 1, 3'd1, 64'h2006, 64'hBEEF, 64'h0, 5'd3, 3, 2, 64'h0,
                1, 64'hBEEF_0000_0000_0000, 8'hC0);
        // misaligned lw
        run_txn(1, 0, 3'd2, 64'h3002, 64'h0, 64'h0, 5'd4, 0, 0, 64'h0, 0, 64'h0, 8'h00);
        // load timeout, then response in the very last WAIT cycle
        run_txn(1, 0, 3'd3, 64'h5000, 64'h0, 64'h0, 5'd6, 0, T + 5, 64'h1, 0, 64'h0, 8'h00);
        run_txn(1, 0, 3'd2, 64'h5004, 64'h0, 64'h0, 5'd6, 0, T - 1, 64'hCAFEF00D_12345678,
                1, 64'hFFFFFFFF_CAFEF00D, 8'h00);
        // ld into x0
        run_txn(1, 0, 3'd3, 64'h6000, 64'h0, 64'h0, 5'd0, 0, 2, 64'hDEAD, 0, 64'h0, 8'h00);

        // reset during WAIT
        drive_junk(1'b0);
        in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'd3;
        in_addr = 64'h4000; in_rd = 5'd7; mem_rvalid = 0;
        expect_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 0; mem_gnt = 1;
        expect_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        exp_addr = 64'h4000; exp_we = 1'b0;
        tick();
        mem_gnt = 0;
        expect_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) begin
            mem_rvalid = 1'b1;
            mem_rdata  = {$urandom, $urandom};
            expect_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        mem_rvalid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            r_ld = (kind >= 3 && kind <= 6);
            r_st = (kind >= 7);
            r_f3 = r_st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            nb   = 1 << r_f3[1:0];
            off  = ($urandom_range(0, 3) != 0) ? nb * $urandom_range(0, 8 / nb - 1)
                                               : $urandom_range(0, 7);
            r_addr = {$urandom, $urandom};
            r_addr[2:0] = 3'(off);
            gd   = $urandom_range(0, 4);
            pick = $urandom_range(0, 19);
            rv   = (pick == 0) ? T + $urandom_range(0, 3) :
                   (pick == 1) ? T - 1 : $urandom_range(0, 6);
            run_txn(r_ld, r_st, r_f3, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
                    5'($urandom_range(0, 31)), gd, rv, {$urandom, $urandom}, 0, 64'h0, 8'h00);
            repeat ($urandom_range(0, 2)) begin
                drive_junk(1'b0);
                expect_cycle(1'b1, 1'b0, 1'b0, 1'b0);
                tick();
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/ysyx_22040125_lsu.md
YSYX_22040125_LSU -- requirements
Module: ysyx_22040125_LSU

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles spent in WAIT before a response error is raised.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_valid  input  1  SHALL indicate an instruction is offered by the execute stage.
REQ-005 in_ready  output  1  SHALL indicate the unit accepts an instruction this cycle.
REQ-006 in_is_load, in_is_store  input  1 each  SHALL mark a memory op; both low means ALU pass-through.
REQ-007 in_funct3  input  3  SHALL encode size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd, 100 lbu, 101 lhu, 110 lwu.
REQ-008 in_addr  input  64  SHALL carry the effective byte address.
REQ-009 in_wdata  input  64  SHALL carry store data, LSB-aligned.
REQ-010 in_alu  input  64  SHALL carry the result for non-memory instructions.
REQ-011 in_rd  input  5  SHALL carry the destination register index.
REQ-012 mem_req, mem_we  output  1 each  SHALL form the bus request and write qualifier.
REQ-013 mem_addr  output  64  SHALL be in_addr with bits [2:0] cleared.
REQ-014 mem_wdata  output  64; mem_wmask  output  8  SHALL carry lane-shifted store data and byte enables.
REQ-015 mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  64  SHALL form the bus grant and response.
REQ-016 wb_en  output  1; wb_addr  output  5; wb_data  output  64  SHALL drive the register-file write port.
REQ-017 err  output  1  SHALL pulse one cycle on a misaligned access or a response timeout.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, WB; in_ready SHALL be 1 exactly when state is IDLE.
REQ-019 IDLE, in_valid&in_ready: all inputs SHALL be latched; the next state is chosen per REQ-020 to REQ-022.
REQ-020 Neither load nor store -> WB with wb_data=in_alu; wb_en SHALL assert the cycle after acceptance.
REQ-021 Misaligned (offset=in_addr[2:0] not a multiple of the access size) -> err pulse next cycle, no bus access, no writeback, stay IDLE.
REQ-022 Aligned load/store -> REQ.
REQ-023 REQ: mem_req=1 with stable addr/we/wdata/wmask SHALL hold until mem_gnt=1, then -> WAIT.
REQ-024 Store: mem_wmask = size mask (1/3/F/FF hex) << offset; mem_wdata = in_wdata << (8*offset).
REQ-025 WAIT: on mem_rvalid, a load SHALL go to WB and a store SHALL go to IDLE with no writeback.
REQ-026 Load data = mem_rdata >> (8*offset), truncated to size, sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to 64 bits.
REQ-027 WAIT timeout: the counter clears on entry; if it reaches TIMEOUT_CYCLES without mem_rvalid -> err pulse, -> IDLE, no writeback; mem_rvalid arriving in that same cycle SHALL win.
REQ-028 WB: wb_en=1 for exactly one cycle with latched rd and data; rd==0 SHALL suppress wb_en; -> IDLE.
REQ-029 mem_rvalid in IDLE, REQ or WB SHALL be ignored.
REQ-030 wb_en, err and mem_req SHALL be registered (no combinational path from inputs).

Reset
REQ-031 rst_n low SHALL immediately force IDLE: in_ready=1; mem_req, mem_we, wb_en and err are 0; mem_addr, mem_wdata, mem_wmask, wb_addr, wb_data, the latches and the counter are 0.
REQ-032 Reset mid-transaction SHALL abandon it with no writeback and no err after release.

Verification
REQ-033 ALU op: in_alu=0x1234, rd=5 accepted cycle N -> wb_en=1, wb_addr=5, wb_data=0x1234 at N+1 only.
REQ-034 lb addr=0x1003, rdata=0x00000000_80000000 -> mem_addr=0x1000, wb_data=0xFFFFFFFF_FFFFFF80; lbu at the same address -> 0x80.
REQ-035 sh addr=0x2006, wdata=0xBEEF, gnt delayed 3 cycles -> mem_req held 4 cycles, wmask=0xC0, wdata=0xBEEF<<48, no wb_en.
REQ-036 lw addr=0x3002 -> err pulse, mem_req never asserts, in_ready returns to 1.
REQ-037 Load, no rvalid for TIMEOUT_CYCLES -> err pulse, IDLE, no wb_en; separately ld with rd=0 -> no wb_en.
REQ-038 rst_n low during WAIT -> outputs at reset values at once; a later rvalid is ignored.
